// File: rtl/switch_io_pkg.sv
// Shared types for the switch-read path: FSM state encoding and the CPU data width.
package switch_io_pkg;

  localparam int IO_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARM        = 2'd1,
    WAIT_PRESS = 2'd2,
    DONE       = 2'd3
  } sw_state_e;

endpackage

// File: rtl/switch_input_ctrl_btn_debounce.sv
// Confirm-button conditioning: 2-flop synchronizer followed by a
// consecutive-stable-cycles debouncer. btn_stable_o only moves after the
// synchronized level has disagreed with it for DEBOUNCE_CYCLES edges in a row.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic btn_stable_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          btn_sync;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  assign btn_sync     = sync_q[1];
  assign btn_stable_o = stable_q;

  // Two-stage synchronizer for the raw asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], btn_i};
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count,
  // so a pulse shorter than DEBOUNCE_CYCLES never reaches stable_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else if (btn_sync == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_q <= btn_sync;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/switch_input_ctrl.sv
// CPU read of the DIP switch bank gated by a release-then-press handshake on
// the debounced confirm button. The load stalls until the press lands, then
// the synchronized switches are returned zero-extended with a one-cycle strobe.
module switch_input_ctrl
  import switch_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SW_WIDTH        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_req,
  input  logic                 btn_confirm,
  input  logic [SW_WIDTH-1:0]  sw_in,
  output logic                 stall,
  output logic                 rd_valid,
  output logic [IO_DATA_W-1:0] rd_data,
  output logic                 busy
);

  logic [1:0][SW_WIDTH-1:0] sw_sync_q;
  logic                     btn_stable;
  sw_state_e                state_q;
  logic [IO_DATA_W-1:0]     rd_data_q;
  logic                     rd_valid_q;
  logic                     busy_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk          (clk),
    .rst          (rst),
    .btn_i        (btn_confirm),
    .btn_stable_o (btn_stable)
  );

  // Two-stage synchronizer for every switch bit; capture uses stage [1].
  always_ff @(posedge clk) begin
    if (rst) sw_sync_q <= '0;
    else     sw_sync_q <= {sw_sync_q[0], sw_in};
  end

  // Read sequencer. rd_req is only looked at in IDLE, so a decoder dropping it
  // mid-read does not abort. ARM insists on a release first so a press still
  // held from the previous read can never satisfy the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_req) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          if (!btn_stable) state_q <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (btn_stable) begin
            rd_data_q  <= IO_DATA_W'(sw_sync_q[1]);
            rd_valid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational from rd_req so the requesting load stalls in its first cycle.
  assign stall    = (state_q == ARM) || (state_q == WAIT_PRESS) ||
                    ((state_q == IDLE) && rd_req);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Bench for switch_input_ctrl with DEBOUNCE_CYCLES=4. A cycle model built from
// the behavioural rules (sliding window of synchronized button samples, read
// progress needing a release then a press) is stepped alongside the DUT.
module tb_switch_input_ctrl;

  localparam int D = 4;
  localparam int P_IDLE = 0, P_REL = 1, P_PRESS = 2, P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst, rd_req, btn;
  logic [7:0]  sw;
  logic        stall, rd_valid, busy;
  logic [15:0] rd_data;

  int checks = 0;
  int errors = 0;

  // reference model
  int          m_phase;
  bit          m_stable, m_s1, m_s2, m_valid;
  bit   [7:0]  m_sw1, m_sw2;
  bit   [15:0] m_data;
  bit          hist[$];

  logic [15:0] caps[$];
  int          drop_at;

  switch_input_ctrl #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .btn_confirm(btn), .sw_in(sw),
    .stall(stall), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] obs_vec();
    return {stall, rd_valid, busy, rd_data};
  endfunction

  function automatic logic [18:0] exp_vec();
    logic st;
    st = (m_phase == P_REL) || (m_phase == P_PRESS) || ((m_phase == P_IDLE) && rd_req);
    return {st, m_valid, (m_phase != P_IDLE), m_data};
  endfunction

  // One clock: advance the model with the inputs present at the edge,
  // then return at the falling edge where outputs are compared.
  task automatic tick();
    bit st_old, all_diff;
    bit [7:0] sw_old;
    @(posedge clk);
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_sw1 = '0; m_sw2 = '0; m_stable = 0;
      hist.delete(); m_phase = P_IDLE; m_data = '0; m_valid = 0;
    end else begin
      st_old = m_stable;
      sw_old = m_sw2;
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D) begin
        all_diff = 1;
        foreach (hist[i]) if (hist[i] == st_old) all_diff = 0;
        if (all_diff) m_stable = !st_old;
      end
      case (m_phase)
        P_IDLE:  if (rd_req) m_phase = P_REL;
        P_REL:   if (!st_old) m_phase = P_PRESS;
        P_PRESS: if (st_old) begin m_data = {8'h00, sw_old}; m_phase = P_DONE; end
        default: m_phase = P_IDLE;
      endcase
      m_valid = (m_phase == P_DONE);
      m_s2 = m_s1; m_s1 = btn; m_sw2 = m_sw1; m_sw1 = sw;
    end
    @(negedge clk);
  endtask

  // Record a strobe and let the decoder drop rd_req once drop_at reads returned.
  task automatic note_valid();
    if (rd_valid === 1'b1) begin
      caps.push_back(rd_data);
      if (caps.size() >= drop_at) rd_req = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1; rd_req = 0; btn = 0; sw = 8'h5A;
    repeat (3) tick();
    checks++;
    if (obs_vec() !== 19'h0) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs_vec(), 19'h0);
    end
    rst = 0;
    repeat (3) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL reset_idle: dut=%h model=%h", obs_vec(), exp_vec()); end
    end
  endtask

  task automatic test_basic();
    caps.delete(); drop_at = 1;
    sw = 8'hA5; rd_req = 1; btn = 0;
    repeat (6) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL basic_arm: dut=%h model=%h", obs_vec(), exp_vec()); end
    end
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL basic_stall: got %b want 1", stall); end
    btn = 1;
    repeat (14) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL basic_press: dut=%h model=%h", obs_vec(), exp_vec()); end
      note_valid();
    end
    checks++;
    if (caps.size() != 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", caps.size()); end
    else begin
      checks++;
      if (caps[0] !== 16'h00A5) begin errors++; $display("FAIL basic_data: got %h want 00a5", caps[0]); end
    end
    btn = 0;
    repeat (10) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL basic_release: dut=%h model=%h", obs_vec(), exp_vec()); end
    end
  endtask

  task automatic test_glitch();
    caps.delete(); drop_at = 1;
    sw = 8'h77; rd_req = 1; btn = 0;
    repeat (4) tick();
    btn = 1;
    repeat (3) tick();
    btn = 0;
    repeat (12) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL glitch_cycle: dut=%h model=%h", obs_vec(), exp_vec()); end
      note_valid();
    end
    checks++;
    if (caps.size() != 0 || stall !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL glitch_reject: pulses=%0d stall=%b busy=%b want 0/1/1", caps.size(), stall, busy);
    end
    btn = 1;
    repeat (14) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL glitch_finish: dut=%h model=%h", obs_vec(), exp_vec()); end
      note_valid();
    end
    checks++;
    if (caps.size() != 1) begin errors++; $display("FAIL glitch_pulses: got %0d want 1", caps.size()); end
    btn = 0;
    repeat (10) tick();
  endtask

  task automatic test_held();
    caps.delete(); drop_at = 1;
    sw = 8'h42; rd_req = 0; btn = 1;
    repeat (10) tick();
    rd_req = 1;
    repeat (15) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL held_wait: dut=%h model=%h", obs_vec(), exp_vec()); end
      note_valid();
    end
    checks++;
    if (caps.size() != 0 || stall !== 1'b1) begin
      errors++; $display("FAIL held_reuse: pulses=%0d stall=%b want 0/1", caps.size(), stall);
    end
    btn = 0;
    repeat (8) tick();
    btn = 1;
    repeat (14) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL held_press: dut=%h model=%h", obs_vec(), exp_vec()); end
      note_valid();
    end
    checks++;
    if (caps.size() != 1 || (caps.size() == 1 && caps[0] !== 16'h0042)) begin
      errors++; $display("FAIL held_capture: pulses=%0d want 1 with data 0042", caps.size());
    end
    btn = 0;
    repeat (10) tick();
  endtask

  task automatic test_back_to_back();
    caps.delete(); drop_at = 2;
    sw = 8'h01; rd_req = 1; btn = 0;
    repeat (8) tick();
    btn = 1;
    repeat (12) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL b2b_first: dut=%h model=%h", obs_vec(), exp_vec()); end
      note_valid();
    end
    checks++;
    if (caps.size() != 1 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_rearm: pulses=%0d busy=%b want 1/1", caps.size(), busy);
    end
    sw = 8'hFF; btn = 0;
    repeat (8) tick();
    btn = 1;
    repeat (12) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL b2b_second: dut=%h model=%h", obs_vec(), exp_vec()); end
      note_valid();
    end
    checks++;
    if (caps.size() != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", caps.size()); end
    else begin
      checks++;
      if (caps[0] !== 16'h0001 || caps[1] !== 16'h00FF) begin
        errors++; $display("FAIL b2b_data: got %h,%h want 0001,00ff", caps[0], caps[1]);
      end
    end
    btn = 0;
    repeat (10) tick();
  endtask

  task automatic test_switch_change();
    caps.delete(); drop_at = 1;
    sw = 8'h3C; rd_req = 1; btn = 0;
    repeat (4) tick();
    sw = 8'hC3;
    repeat (3) tick();
    btn = 1;
    repeat (14) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL swchg_cycle: dut=%h model=%h", obs_vec(), exp_vec()); end
      note_valid();
    end
    checks++;
    if (caps.size() != 1 || (caps.size() == 1 && caps[0] !== 16'h00C3)) begin
      errors++; $display("FAIL swchg_data: pulses=%0d data=%h want 1 with 00c3", caps.size(), rd_data);
    end
    btn = 0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid_read();
    caps.delete(); drop_at = 1;
    sw = 8'h99; rd_req = 1; btn = 0;
    repeat (6) tick();
    btn = 1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1 || rd_data === 16'h0000) begin
      errors++; $display("FAIL rstmid_pre: busy=%b data=%h want busy 1 with prior nonzero data", busy, rd_data);
    end
    rst = 1;
    repeat (2) tick();
    checks++;
    if ({rd_valid, busy, rd_data} !== 18'h0 || stall !== 1'b1) begin
      errors++; $display("FAIL rstmid_state: valid=%b busy=%b data=%h stall=%b want 0/0/0000/1", rd_valid, busy, rd_data, stall);
    end
    rst = 0; rd_req = 0; btn = 0;
    repeat (10) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL rstmid_after: dut=%h model=%h", obs_vec(), exp_vec()); end
    end
  endtask

  task automatic test_random();
    caps.delete(); drop_at = 1;
    for (int seg = 0; seg < 80; seg++) begin
      if (rd_req === 1'b0) rd_req = ($urandom_range(0, 2) != 0);
      btn = $urandom_range(0, 1);
      sw  = 8'($urandom);
      repeat ($urandom_range(1, 9)) begin
        tick(); checks++;
        if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL random_cycle: seg=%0d dut=%h model=%h", seg, obs_vec(), exp_vec()); end
        if (rd_valid === 1'b1) begin caps.delete(); rd_req = 0; end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_held();
    test_back_to_back();
    test_switch_change();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_input_ctrl.md
# switch_input_ctrl

Sequences CPU reads of the 8-bit DIP switch bank through a confirm-button handshake. A switch-space load from the memory/IO decoder stalls the pipeline until the user releases and then presses the debounced confirm button. The block then captures the synchronized switches and returns them zero-extended to 16 bits. It sits between the memory/IO address decoder and the board switch/button pins, and replaces direct sampling of the switches.

## Interface
- DEBOUNCE_CYCLES, default 20000 — consecutive stable cycles needed before the button level is accepted; minimum 1.
- SW_WIDTH, default 8 — switch bank width; result is zero-extended to 16 bits.

- clk  in  1  system clock; all state updates on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- rd_req  in  1  level request from the memory/IO decoder: CPU executing a switch-space load.
- btn_confirm  in  1  raw asynchronous confirm button, active-high.
- sw_in  in  SW_WIDTH  raw asynchronous switch levels.
- stall  out  1  holds the CPU pipeline while a read is pending.
- rd_valid  out  1  one-cycle strobe: rd_data holds this read's result.
- rd_data  out  16  {zeros, captured switches}; holds its value between captures.
- busy  out  1  FSM not in IDLE; for debug LED.

## Operation
- Input sync: btn_confirm and each sw_in bit each pass through 2 flops (btn_sync, sw_sync). Reset value of all sync flops is 0.
- Debounce: btn_stable (reset 0) and cnt (width $clog2(DEBOUNCE_CYCLES+1), reset 0).
  - When btn_sync == btn_stable, cnt <= 0.
  - When they differ and cnt == DEBOUNCE_CYCLES-1: btn_stable <= btn_sync and cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES is rejected.
- FSM states: IDLE, ARM, WAIT_PRESS, DONE. Reset state is IDLE.
  - IDLE: if rd_req, go to ARM. rd_req is sampled only in IDLE.
  - ARM: wait for btn_stable==0, then go to WAIT_PRESS. A button still held from a previous read is never reused.
  - WAIT_PRESS: on btn_stable==1, set rd_data <= {{16-SW_WIDTH{1'b0}}, sw_sync} and go to DONE.
  - DONE: rd_valid=1, then go to IDLE unconditionally.
- stall = (state==ARM) | (state==WAIT_PRESS) | (state==IDLE & rd_req). It is combinational from rd_req so the requesting load stalls in its first cycle.
  - stall=0 in DONE; the CPU completes the load that cycle and must deassert rd_req on the next edge.
  - If rd_req is still high in IDLE after DONE, a new read starts; this is the back-to-back case.
- busy = (state != IDLE).
- rd_req dropping in ARM or WAIT_PRESS does not abort the read. The read completes normally; the decoder never does this.

## Timing
- Reset values: stall=0 (IDLE with rd_req=0), rd_valid=0, rd_data=0, busy=0. The debounce counter and btn_stable clear.
- Reset mid-read: on the next edge, return to IDLE, rd_data=0 and no rd_valid. stall follows rd_req combinationally after reset.
- Button path latency: a raw rising edge at edge t appears on btn_sync at t+2. btn_stable rises at t+2+DEBOUNCE_CYCLES if the level holds.
- The capture edge is the first edge in WAIT_PRESS with btn_stable=1. rd_valid is high for exactly the following cycle.
- Minimum read latency, with the button already released and debounced: IDLE→ARM→WAIT_PRESS takes 2 edges; then the press path; then DONE for 1 cycle.
- rd_data changes only on the capture edge and never glitches while rd_valid=0.

## Structure
- Package switch_io_pkg holds the FSM state enum (2-bit: IDLE=0, ARM=1, WAIT_PRESS=2, DONE=3) and the IO_DATA_W=16 constant.
- One sub-module, btn_debounce, containing the 2-flop sync, counter and btn_stable, parameterized by DEBOUNCE_CYCLES.
- Switch sync flops, FSM and capture register stay in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert rst for 2 cycles mid-WAIT_PRESS → state IDLE, rd_data=16'h0000, rd_valid=0, busy=0.
- Basic read: sw_in=8'hA5, rd_req=1, button released, then pressed and held 10 cycles → stall high until DONE, one rd_valid pulse, rd_data=16'h00A5.
- Glitch rejection: in WAIT_PRESS, pulse button high for 3 cycles, then low → btn_stable stays 0, no capture, stall stays high.
- Held button: button already held when rd_req rises → FSM waits in ARM; release ≥4 cycles, press ≥4 cycles → capture. No capture occurs while the original press is held.
- Back-to-back: keep rd_req high through DONE with sw_in changing 8'h01 → 8'hFF between presses → two reads return 16'h0001 then 16'h00FF. Each read requires its own release-press cycle.
- Switch change mid-wait: change sw_in from 8'h3C to 8'hC3 during WAIT_PRESS, then press → rd_data=16'h00C3, which is the synchronized value at the capture edge.
